// File: rtl/my_isolation_ctrl_pkg.sv
// Shared encodings for the per-unit operand-isolation sequencer and the
// isolation gates that consume its enables.
package my_isolation_ctrl_pkg;

  // Per-unit sequencer states
  typedef enum logic [1:0] {
    ISOLATED = 2'd0,
    WAKING   = 2'd1,
    ACTIVE   = 2'd2
  } unitState_t;

  // Enable polarity seen by the isolation gates
  localparam logic ISO_PASS  = 1'b1;
  localparam logic ISO_BLOCK = 1'b0;

endpackage

// File: rtl/my_isolation_unit_fsm.sv
// One functional unit's isolation sequencer: ISOLATED -> WAKING -> ACTIVE,
// timing out back to ISOLATED after IDLE_CYCLES request-free cycles.
// A single counter serves as the wake counter in WAKING and as the idle
// counter in ACTIVE; the two uses never overlap.
module my_isolation_unit_fsm
  import my_isolation_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic iClk,
  input  logic iReset_n,
  input  logic req,
  output logic enable,
  output logic ready,
  output logic is_isolated
);

  localparam logic [CNT_WIDTH-1:0] IDLE_LOAD = CNT_WIDTH'(IDLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WAKE_LOAD =
    CNT_WIDTH'((WAKE_CYCLES > 0) ? (WAKE_CYCLES - 1) : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  unitState_t           state, stateNext;
  logic [CNT_WIDTH-1:0] cnt, cntNext;

  // Next-state and counter update; a request always wins over idle expiry
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      ISOLATED: begin
        if (req) begin
          if (WAKE_CYCLES == 0) begin
            stateNext = ACTIVE;
            cntNext   = IDLE_LOAD;
          end else begin
            stateNext = WAKING;
            cntNext   = WAKE_LOAD;
          end
        end
      end
      WAKING: begin
        // Wake always completes, even if the request has gone away
        if (cnt == '0) begin
          stateNext = ACTIVE;
          cntNext   = IDLE_LOAD;
        end else begin
          cntNext = cnt - CNT_ONE;
        end
      end
      ACTIVE: begin
        if (req) begin
          cntNext = IDLE_LOAD;
        end else if (cnt != '0) begin
          cntNext = cnt - CNT_ONE;
        end else begin
          stateNext = ISOLATED;
          cntNext   = '0;
        end
      end
      default: begin
        stateNext = ISOLATED;
        cntNext   = '0;
      end
    endcase
  end

  // State, counter and registered output decodes of the next state
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state       <= ISOLATED;
      cnt         <= '0;
      enable      <= ISO_BLOCK;
      ready       <= 1'b0;
      is_isolated <= 1'b1;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      enable      <= (stateNext != ISOLATED) ? ISO_PASS : ISO_BLOCK;
      ready       <= (stateNext == ACTIVE);
      is_isolated <= (stateNext == ISOLATED);
    end
  end

endmodule

// File: rtl/my_isolation_ctrl.sv
// Per-PE operand-isolation controller: one independent sequencer per
// functional unit, plus an all-isolated summary flag.
module my_isolation_ctrl
  import my_isolation_ctrl_pkg::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                 iClk,
  input  logic                 iReset_n,
  input  logic [NUM_UNITS-1:0] iUnit_Req,
  input  logic                 iForce_Active,
  output logic [NUM_UNITS-1:0] oIsolation_Signal,
  output logic [NUM_UNITS-1:0] oUnit_Ready,
  output logic                 oAll_Isolated
);

  logic [NUM_UNITS-1:0] effReq;
  logic [NUM_UNITS-1:0] unitIsolated;

  // Force makes every unit look requested every cycle
  always_comb effReq = iUnit_Req | {NUM_UNITS{iForce_Active}};

  for (genvar g = 0; g < NUM_UNITS; g++) begin : gUnit
    my_isolation_unit_fsm #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES),
      .CNT_WIDTH   (CNT_WIDTH)
    ) uFsm (
      .iClk        (iClk),
      .iReset_n    (iReset_n),
      .req         (effReq[g]),
      .enable      (oIsolation_Signal[g]),
      .ready       (oUnit_Ready[g]),
      .is_isolated (unitIsolated[g])
    );
  end

  // Per-unit flags are registered, so the summary carries no extra state
  always_comb oAll_Isolated = &unitIsolated;

endmodule
